// File: rtl/tytra_stream_lane_kernel.sv
// Lane-parallel add stage between the read-master and write-master AXI4-Streams.
// Two registered stages plus a one-entry input skid, so s_axis_tready never depends on m_axis_tready.
module tytra_stream_lane_kernel #(
    parameter int C_DATA_WIDTH = 512,
    parameter int C_LANE_WIDTH = 32,
    parameter int C_SATURATE   = 0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    ctrl_start,
    input  logic [C_LANE_WIDTH-1:0] ctrl_constant,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [31:0]             stat_beat_count
);
    localparam int unsigned LW    = C_LANE_WIDTH;
    localparam int unsigned LANES = C_DATA_WIDTH / C_LANE_WIDTH;

    logic [LW-1:0]           const_q;
    logic                    skid_valid;
    logic [C_DATA_WIDTH-1:0] skid_data;
    logic                    skid_last;
    logic                    s1_valid;
    logic [C_DATA_WIDTH-1:0] s1_data;
    logic                    s1_last;

    logic                    adv;
    logic                    s_hs;
    logic                    m_hs;
    logic                    skid_next;
    logic                    in_valid;
    logic [C_DATA_WIDTH-1:0] in_data;
    logic                    in_last;
    logic [C_DATA_WIDTH-1:0] sum_data;
    logic [LW:0]             lane_sum;

    assign adv       = ~m_axis_tvalid | m_axis_tready;
    assign s_hs      = s_axis_tvalid & s_axis_tready;
    assign m_hs      = m_axis_tvalid & m_axis_tready;
    assign skid_next = ~adv & (skid_valid | s_hs);

    // tready is low whenever the skid holds a beat, so skid and live beat never coexist.
    always_comb begin
        in_valid = skid_valid | s_hs;
        in_data  = skid_valid ? skid_data : s_axis_tdata;
        in_last  = skid_valid ? skid_last : (s_hs & s_axis_tlast);
    end

    always_comb begin
        sum_data = '0;
        lane_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_sum = {1'b0, in_data[i*LW +: LW]} + {1'b0, const_q};
            if ((C_SATURATE != 0) && lane_sum[LW])
                sum_data[i*LW +: LW] = '1;
            else
                sum_data[i*LW +: LW] = lane_sum[LW-1:0];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            skid_valid    <= 1'b0;
            skid_data     <= '0;
            skid_last     <= 1'b0;
            s_axis_tready <= 1'b1;
            s1_valid      <= 1'b0;
            s1_data       <= '0;
            s1_last       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            skid_valid    <= skid_next;
            s_axis_tready <= ~skid_next;
            if (!adv && s_hs) begin
                skid_data <= s_axis_tdata;
                skid_last <= s_axis_tlast;
            end
            if (adv) begin
                s1_valid      <= in_valid;
                s1_data       <= sum_data;
                s1_last       <= in_last;
                m_axis_tvalid <= s1_valid;
                m_axis_tdata  <= s1_data;
                m_axis_tlast  <= s1_last;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            const_q         <= '0;
            stat_beat_count <= '0;
        end else begin
            if (ctrl_start)
                const_q <= ctrl_constant;
            if (ctrl_start)
                stat_beat_count <= m_hs ? 32'd1 : 32'd0;
            else if (m_hs)
                stat_beat_count <= stat_beat_count + 32'd1;
        end
    end

endmodule
